// File: rtl/seven_seg_scan_ctrl_if.sv
// Bus between the scan controller and its host / display hardware.
// The host (master) loads new BCD values. The controller (slave) drives the
// shared decoder code and the digit enables.
interface seven_seg_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  load_ready;
    logic [3:0]            bcd_sel;
    logic [DIGITS-1:0]     digit_en;
    logic                  frame_start;

    modport master (
        output load, bcd_in,
        input  load_ready, bcd_sel, digit_en, frame_start
    );

    modport slave (
        input  load, bcd_in,
        output load_ready, bcd_sel, digit_en, frame_start
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// - One digit slot is a one-cycle all-off GAP followed by DIV DRIVE cycles.
// - New values are double-buffered (staging -> display) and swapped only at
//   the frame boundary, so a frame never mixes old and new digits.
// - All outputs are registered copies of the current FSM state's decode, so
//   what is visible lags the FSM state by one cycle.
// Optional feature: define SEVEN_SEG_SCAN_LZB_EN for leading-zero blanking.
module seven_seg_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 1000
) (
    input  logic                 clock,
    input  logic                 reset,
    seven_seg_scan_ctrl_if.slave bus
);
    localparam int CW = $clog2(DIV + 1);
    localparam int IW = $clog2(DIGITS);
    localparam int DW = 4 * DIGITS;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    typedef enum logic {GAP, DRIVE} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [IW-1:0]     idx, idx_nx;

    logic [DW-1:0]     staging, display;
    logic              pending;

    logic [DIGITS-1:0] digit_en_q, digit_en_nx;
    logic [3:0]        bcd_sel_q, bcd_sel_nx;
    logic              frame_start_q, frame_start_nx;

    logic [3:0]        cur_code;
    logic              blank;
    logic              frame_end;

    // Code of the digit currently being scanned.
    assign cur_code = display[{idx, 2'b00} +: 4];

`ifdef SEVEN_SEG_SCAN_LZB_EN
    // A digit above 0 is blanked when it and all more-significant digits are 0.
    logic [DW-1:0] upper;
    assign upper = display >> {idx, 2'b00};
    assign blank = (idx != '0) && (upper == '0);
`else
    assign blank = 1'b0;
`endif

    // Last DRIVE cycle of the last digit: the frame boundary / swap edge.
    assign frame_end = (state == DRIVE) && (cnt == CNT_LAST) && (idx == IDX_LAST);

    // FSM state, prescaler and digit index registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= GAP;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
        end
    end

    // Next-state logic and decode of the outputs for the current state.
    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        idx_nx         = idx;
        digit_en_nx    = '0;
        bcd_sel_nx     = 4'hF;
        frame_start_nx = 1'b0;
        case (state)
            GAP: begin
                state_nx = DRIVE;
                cnt_nx   = '0;
            end
            DRIVE: begin
                digit_en_nx    = DIGITS'(1) << idx;
                bcd_sel_nx     = blank ? 4'hF : cur_code;
                frame_start_nx = (idx == '0) && (cnt == '0);
                if (cnt == CNT_LAST) begin
                    state_nx = GAP;
                    cnt_nx   = '0;
                    idx_nx   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = GAP;
                cnt_nx   = '0;
                idx_nx   = '0;
            end
        endcase
    end

    // Registered outputs; reset forces the all-off state immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            digit_en_q    <= '0;
            bcd_sel_q     <= 4'hF;
            frame_start_q <= 1'b0;
        end else begin
            digit_en_q    <= digit_en_nx;
            bcd_sel_q     <= bcd_sel_nx;
            frame_start_q <= frame_start_nx;
        end
    end

    // Double buffer: accept a load when idle, swap it in at the frame boundary.
    // Load acceptance needs pending=0 and the swap needs pending=1, so the two
    // never coincide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            staging <= '0;
            display <= '0;
            pending <= 1'b0;
        end else if (bus.load && !pending) begin
            staging <= bus.bcd_in;
            pending <= 1'b1;
        end else if (frame_end && pending) begin
            display <= staging;
            pending <= 1'b0;
        end
    end

    assign bus.load_ready  = !pending;
    assign bus.digit_en    = digit_en_q;
    assign bus.bcd_sel     = bcd_sel_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed testbench for seven_seg_scan_ctrl with DIGITS=4, DIV=3
// (slot = 4 cycles, frame = 16 cycles). Outputs are sampled on the falling
// edge; "k" below is the number of rising edges since reset was released.
module tb_seven_seg_scan_ctrl;
    localparam int DIGITS = 4;
    localparam int DIV    = 3;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    seven_seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

    seven_seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference digit value for a displayed word, including optional blanking.
    function automatic logic [3:0] ref_digit(input logic [15:0] disp, input int slot);
        logic [15:0] up;
        up = disp >> (4 * slot);
`ifdef SEVEN_SEG_SCAN_LZB_EN
        if (slot != 0 && up == 16'h0000) return 4'hF;
`endif
        return up[3:0];
    endfunction

    // Hold reset for two cycles, release it just after a falling edge.
    task automatic do_reset();
        @(negedge clock);
        reset       = 1'b1;
        bus.load    = 1'b0;
        bus.bcd_in  = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int p, slot, pos;
        logic [3:0] exp_en;
        logic       exp_fs;
        do_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (bus.digit_en !== 4'b0000 || bus.bcd_sel !== 4'hF ||
            bus.frame_start !== 1'b0 || bus.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_vals: en=%b sel=%h fs=%b lr=%b want 0000 f 0 1",
                     bus.digit_en, bus.bcd_sel, bus.frame_start, bus.load_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clock);
            @(negedge clock);
            p      = (k - 1) % 16;
            slot   = p / 4;
            pos    = p % 4;
            exp_en = (pos == 0) ? 4'b0000 : (4'b0001 << slot);
            exp_fs = (p == 1);
            checks++;
            if (bus.digit_en !== exp_en) begin
                errors++;
                $display("FAIL scan_en k=%0d: got %b want %b", k, bus.digit_en, exp_en);
            end
            checks++;
            if (bus.frame_start !== exp_fs) begin
                errors++;
                $display("FAIL frame_start k=%0d: got %b want %b", k, bus.frame_start, exp_fs);
            end
        end
    endtask

    task automatic test_load_swap();
        int p, slot, pos;
        logic [15:0] disp;
        logic [3:0]  exp_sel;
        logic        exp_lr;
        do_reset();
        bus.load   = 1'b1;
        bus.bcd_in = 16'h1234;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clock);
            @(negedge clock);
            p       = (k - 1) % 16;
            slot    = p / 4;
            pos     = p % 4;
            disp    = (k <= 16) ? 16'h0000 : 16'h1234;
            exp_sel = (pos == 0) ? 4'hF : ref_digit(disp, slot);
            exp_lr  = (k >= 16);
            checks++;
            if (bus.bcd_sel !== exp_sel) begin
                errors++;
                $display("FAIL swap_sel k=%0d: got %h want %h", k, bus.bcd_sel, exp_sel);
            end
            checks++;
            if (bus.load_ready !== exp_lr) begin
                errors++;
                $display("FAIL swap_ready k=%0d: got %b want %b", k, bus.load_ready, exp_lr);
            end
            if (k == 1) begin
                bus.load   = 1'b0;
                bus.bcd_in = '0;
            end
        end
    endtask

    task automatic test_load_busy();
        int p, slot, pos;
        logic [3:0] exp_sel;
        do_reset();
        bus.load   = 1'b1;
        bus.bcd_in = 16'h1234;
        for (int k = 1; k <= 48; k++) begin
            @(posedge clock);
            @(negedge clock);
            p    = (k - 1) % 16;
            slot = p / 4;
            pos  = p % 4;
            if (k > 16 && pos != 0) begin
                exp_sel = ref_digit(16'h1234, slot);
                checks++;
                if (bus.bcd_sel !== exp_sel) begin
                    errors++;
                    $display("FAIL busy_sel k=%0d: got %h want %h", k, bus.bcd_sel, exp_sel);
                end
            end
            // Second load held while busy, dropped well before the swap edge.
            if (k == 1) bus.bcd_in = 16'h5678;
            if (k == 10) begin
                bus.load   = 1'b0;
                bus.bcd_in = '0;
            end
        end
    endtask

    task automatic test_lzb();
        logic [3:0] exp_a [4];
        logic [3:0] exp_b [4];
        logic [3:0] exp_sel;
        int p, slot, pos;
`ifdef SEVEN_SEG_SCAN_LZB_EN
        exp_a = '{4'h0, 4'h5, 4'hF, 4'hF};
        exp_b = '{4'h0, 4'hF, 4'hF, 4'hF};
`else
        exp_a = '{4'h0, 4'h5, 4'h0, 4'h0};
        exp_b = '{4'h0, 4'h0, 4'h0, 4'h0};
`endif
        do_reset();
        // Preload a nonzero value so the later 0000 frame is a real change.
        bus.load   = 1'b1;
        bus.bcd_in = 16'h0050;
        for (int k = 1; k <= 48; k++) begin
            @(posedge clock);
            @(negedge clock);
            p    = (k - 1) % 16;
            slot = p / 4;
            pos  = p % 4;
            if (k > 16 && pos != 0) begin
                exp_sel = (k <= 32) ? exp_a[slot] : exp_b[slot];
                checks++;
                if (bus.bcd_sel !== exp_sel) begin
                    errors++;
                    $display("FAIL lzb_sel k=%0d: got %h want %h", k, bus.bcd_sel, exp_sel);
                end
            end
            if (k == 1) bus.load = 1'b0;
            if (k == 16) begin
                bus.load   = 1'b1;
                bus.bcd_in = 16'h0000;
            end
            if (k == 17) bus.load = 1'b0;
        end
    endtask

    task automatic test_mid_reset();
        int p, slot, pos;
        logic [3:0] exp_sel;
        do_reset();
        bus.load   = 1'b1;
        bus.bcd_in = 16'h1234;
        for (int k = 1; k <= 27; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (k == 1) bus.load = 1'b0;
            if (k == 16) begin
                bus.load   = 1'b1;
                bus.bcd_in = 16'h5678;
            end
            if (k == 17) bus.load = 1'b0;
        end
        // After edge 27: digit 2 DRIVE of frame 1 with 5678 pending.
        checks++;
        if (bus.digit_en !== 4'b0100 || bus.bcd_sel !== 4'h2 || bus.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset: en=%b sel=%h lr=%b want 0100 2 0",
                     bus.digit_en, bus.bcd_sel, bus.load_ready);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.digit_en !== 4'b0000 || bus.bcd_sel !== 4'hF ||
            bus.frame_start !== 1'b0 || bus.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: en=%b sel=%h fs=%b lr=%b want 0000 f 0 1",
                     bus.digit_en, bus.bcd_sel, bus.frame_start, bus.load_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clock);
            @(negedge clock);
            p       = (k - 1) % 16;
            slot    = p / 4;
            pos     = p % 4;
            exp_sel = (pos == 0) ? 4'hF : ref_digit(16'h0000, slot);
            checks++;
            if (bus.bcd_sel !== exp_sel || bus.load_ready !== 1'b1) begin
                errors++;
                $display("FAIL restart k=%0d: sel=%h lr=%b want %h 1",
                         k, bus.bcd_sel, bus.load_ready, exp_sel);
            end
            if (k == 2) begin
                checks++;
                if (bus.digit_en !== 4'b0001 || bus.frame_start !== 1'b1) begin
                    errors++;
                    $display("FAIL restart_d0: en=%b fs=%b want 0001 1",
                             bus.digit_en, bus.frame_start);
                end
            end
        end
    endtask

    task automatic test_invalid();
        logic [3:0] exp [4];
        int p, slot, pos;
`ifdef SEVEN_SEG_SCAN_LZB_EN
        exp = '{4'h0, 4'hA, 4'hF, 4'hF};
`else
        exp = '{4'h0, 4'hA, 4'h0, 4'h0};
`endif
        do_reset();
        bus.load   = 1'b1;
        bus.bcd_in = 16'h00A0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clock);
            @(negedge clock);
            p    = (k - 1) % 16;
            slot = p / 4;
            pos  = p % 4;
            if (k == 1) bus.load = 1'b0;
            if (k > 16 && pos != 0) begin
                checks++;
                if (bus.bcd_sel !== exp[slot]) begin
                    errors++;
                    $display("FAIL invalid_sel k=%0d: got %h want %h", k, bus.bcd_sel, exp[slot]);
                end
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        bus.load   = 1'b0;
        bus.bcd_in = '0;
        test_reset();
        test_load_swap();
        test_load_busy();
        test_lzb();
        test_mid_reset();
        test_invalid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
